conv1d_stream_engine: RTL and testbench

- Parametrised, multi-cycle 1-D convolution CFU engine. It holds one int8 input tensor (length x channels), one kernel (KERNEL_LEN x channels), and one int32 output vector.
- A 4-lane MAC array walks the computation sequentially. Padding is implicit, so no pad rows are stored.
- Sits behind the CPU CFU port. Every accepted command yields exactly one response; START responds only when computation completes.

---
 rtl/conv1d_stream_pkg.sv | 31 +++
 rtl/conv1d_mac4.sv | 43 ++++
 rtl/conv1d_stream_engine.sv | 210 +++++++++++++++++++++
 tb/tb_conv1d_stream_engine.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv1d_stream_pkg.sv
// Shared command codes, FSM states and sizing helpers for the 1-D convolution CFU engine.
package conv1d_stream_pkg;

  localparam int LANES          = 4;
  localparam int DEF_MAX_LEN    = 1024;
  localparam int DEF_MAX_CH     = 128;
  localparam int DEF_KERNEL_LEN = 8;

  localparam logic [6:0] CMD_CLEAR   = 7'd0;
  localparam logic [6:0] CMD_WR_IN   = 7'd1;
  localparam logic [6:0] CMD_WR_KER  = 7'd2;
  localparam logic [6:0] CMD_RD_OUT  = 7'd3;
  localparam logic [6:0] CMD_START   = 7'd4;
  localparam logic [6:0] CMD_SET_Q   = 7'd5;
  localparam logic [6:0] CMD_SET_CFG = 7'd6;
  localparam logic [6:0] CMD_STATUS  = 7'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_ACK,
    ST_RESP
  } state_t;

  // Address width for a memory or counter covering n entries (at least one bit).
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv1d_mac4.sv
// Four-lane (in + offset) * ker sum, one register stage; 1-cycle latency, no backpressure.
// A padded or idle step registers zero so the accumulator can add unconditionally.
module conv1d_mac4
  import conv1d_stream_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vld,
  input  logic             pad,
  input  logic [31:0]      in_word,
  input  logic [31:0]      ker_word,
  input  logic [8:0]       offset,
  output logic [ACC_W-1:0] sum
);

  logic signed [19:0] lane_sum;
  logic signed [9:0]  x;
  logic signed [17:0] p;

  always_comb begin
    lane_sum = '0;
    x        = '0;
    p        = '0;
    for (int l = 0; l < LANES; l++) begin
      x = $signed({{2{in_word[31-8*l]}}, in_word[31-8*l -: 8]}) + $signed({offset[8], offset});
      p = $signed({{8{x[9]}}, x}) * $signed({{10{ker_word[31-8*l]}}, ker_word[31-8*l -: 8]});
      lane_sum = lane_sum + $signed({{2{p[17]}}, p});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum <= '0;
    end else if (vld && !pad) begin
      sum <= {{(ACC_W-20){lane_sum[19]}}, lane_sum};
    end else begin
      sum <= '0;
    end
  end

endmodule

// File: rtl/conv1d_stream_engine.sv
// CFU 1-D convolution engine: buffers, config and a sequential 4-lane MAC walk of len*(K*ch/4+1) cycles.
// One response per accepted command; cmd_ready drops while busy or while a response waits for rsp_ready.
module conv1d_stream_engine
  import conv1d_stream_pkg::*;
#(
  parameter int MAX_LEN    = DEF_MAX_LEN,
  parameter int MAX_CH     = DEF_MAX_CH,
  parameter int KERNEL_LEN = DEF_KERNEL_LEN,
  parameter int ACC_W      = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  localparam int GRP    = MAX_CH / LANES;
  localparam int LEN_AW = addr_w(MAX_LEN);
  localparam int GRP_AW = addr_w(GRP);
  localparam int KER_AW = addr_w(KERNEL_LEN);
  localparam int IN_AW  = addr_w(MAX_LEN * GRP);
  localparam int KW_AW  = addr_w(KERNEL_LEN * GRP);
  localparam logic signed [LEN_AW+1:0] HALF_K = (LEN_AW+2)'(KERNEL_LEN / 2);
  localparam logic signed [ACC_W-1:0]  S8_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0]  S8_MIN = ACC_W'(-128);

  logic [31:0]      in_mem  [MAX_LEN*GRP];
  logic [31:0]      ker_mem [KERNEL_LEN*GRP];
  logic [ACC_W-1:0] out_mem [MAX_LEN];

  state_t            state, state_nxt;
  logic [LEN_AW:0]   len_q;
  logic [5:0]        ngrp_q;
  logic [ACC_W-1:0]  bias_q, acc_q;
  logic [8:0]        off_q;
  logic              sat8_q, wb_q, rd_q;
  logic [LEN_AW-1:0] o_q, idx_q;
  logic [KER_AW-1:0] k_q;
  logic [GRP_AW-1:0] g_q, g_max;
  logic [31:0]       cyc_q, rsp_dat;

  logic [6:0]              funct7;
  logic                    accept, cfg_ok, pad, last_kg, last_o, unused_bits;
  logic signed [LEN_AW+1:0] row;
  logic [LEN_AW:0]         len_m1;
  logic [IN_AW-1:0]        in_addr;
  logic [KW_AW-1:0]        kw_addr;
  logic [ACC_W-1:0]        mac_sum, wb_sum, wb_val;

  assign funct7      = cmd_payload_function_id[9:3];
  assign unused_bits = ^cmd_payload_function_id[2:0];
  assign cmd_ready   = (state == ST_IDLE) && !rsp_valid;
  assign accept      = cmd_valid && cmd_ready;
  assign rsp_payload_outputs_0 = rsp_dat;
  assign g_max       = GRP_AW'(ngrp_q - 6'd1);
  assign len_m1      = len_q - 1'b1;

  assign cfg_ok = (cmd_payload_inputs_0[15:0] != 16'd0) &&
                  (cmd_payload_inputs_0[15:0] <= 16'(MAX_LEN)) &&
                  (cmd_payload_inputs_1[1:0] == 2'd0) &&
                  (cmd_payload_inputs_1[7:0] != 8'd0) &&
                  (cmd_payload_inputs_1[7:0] <= 8'(MAX_CH));

  // Rows outside [0, len) are implicit padding: address forced to 0 and the MAC lane masked.
  always_comb begin
    row     = $signed({2'b00, o_q}) + $signed({{(LEN_AW+2-KER_AW){1'b0}}, k_q}) - HALF_K;
    pad     = row[LEN_AW+1] || (row >= $signed({1'b0, len_q}));
    in_addr = pad ? '0 : IN_AW'(row[LEN_AW-1:0]) * IN_AW'(GRP) + IN_AW'(g_q);
    kw_addr = KW_AW'(k_q) * KW_AW'(GRP) + KW_AW'(g_q);
    last_kg = (k_q == KER_AW'(KERNEL_LEN - 1)) && (g_q == g_max);
    last_o  = ({1'b0, o_q} == len_m1);
    // The last product is still in the MAC register during writeback, so it is folded in here.
    wb_sum  = acc_q + mac_sum + bias_q;
    wb_val  = wb_sum;
    if (sat8_q) begin
      if ($signed(wb_sum) > S8_MAX)      wb_val = S8_MAX;
      else if ($signed(wb_sum) < S8_MIN) wb_val = S8_MIN;
    end
  end

  conv1d_mac4 #(.ACC_W(ACC_W)) u_mac (
    .clk      (clk),
    .reset    (reset),
    .vld      ((state == ST_RUN) && !wb_q),
    .pad      (pad),
    .in_word  (in_mem[in_addr]),
    .ker_word (ker_mem[kw_addr]),
    .offset   (off_q),
    .sum      (mac_sum)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (funct7 == CMD_CLEAR)      state_nxt = ST_CLEAR;
          else if (funct7 == CMD_START) state_nxt = ST_RUN;
          else                          state_nxt = ST_ACK;
        end
      end
      ST_CLEAR: if (o_q == LEN_AW'(MAX_LEN - 1)) state_nxt = ST_RESP;
      ST_RUN:   if (wb_q && last_o) state_nxt = ST_RESP;
      ST_ACK:   state_nxt = ST_RESP;
      ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      len_q     <= (LEN_AW+1)'(MAX_LEN);
      ngrp_q    <= 6'(GRP);
      bias_q    <= '0;
      off_q     <= '0;
      sat8_q    <= 1'b0;
      o_q       <= '0;
      k_q       <= '0;
      g_q       <= '0;
      wb_q      <= 1'b0;
      cyc_q     <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      rd_q      <= 1'b0;
    end else begin
      rsp_valid <= (state_nxt == ST_RESP);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            o_q     <= '0;
            k_q     <= '0;
            g_q     <= '0;
            wb_q    <= 1'b0;
            cyc_q   <= '0;
            acc_q   <= '0;
            rd_q    <= (funct7 == CMD_RD_OUT);
            idx_q   <= cmd_payload_inputs_0[LEN_AW-1:0];
            rsp_dat <= '0;
            case (funct7)
              CMD_SET_Q: begin
                bias_q <= ACC_W'(cmd_payload_inputs_0);
                off_q  <= cmd_payload_inputs_1[8:0];
                sat8_q <= cmd_payload_inputs_1[16];
              end
              CMD_SET_CFG: begin
                if (cfg_ok) begin
                  len_q  <= (LEN_AW+1)'(cmd_payload_inputs_0[15:0]);
                  ngrp_q <= cmd_payload_inputs_1[7:2];
                end else begin
                  rsp_dat <= 32'd1;
                end
              end
              CMD_STATUS: rsp_dat <= {30'b0, sat8_q, 1'b1};
              CMD_CLEAR, CMD_WR_IN, CMD_WR_KER, CMD_RD_OUT, CMD_START: ;
              default: rsp_dat <= '1;
            endcase
          end
        end
        ST_CLEAR: o_q <= o_q + 1'b1;
        ST_RUN: begin
          cyc_q <= cyc_q + 1'b1;
          if (!wb_q) begin
            acc_q <= acc_q + mac_sum;
            if (last_kg) begin
              wb_q <= 1'b1;
              k_q  <= '0;
              g_q  <= '0;
            end else if (g_q == g_max) begin
              g_q <= '0;
              k_q <= k_q + 1'b1;
            end else begin
              g_q <= g_q + 1'b1;
            end
          end else begin
            wb_q  <= 1'b0;
            acc_q <= '0;
            o_q   <= o_q + 1'b1;
            if (last_o) rsp_dat <= cyc_q + 1'b1;
          end
        end
        ST_ACK: if (rd_q) rsp_dat <= 32'(out_mem[idx_q]);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept && funct7 == CMD_WR_IN)  in_mem[cmd_payload_inputs_0[IN_AW-1:0]]  <= cmd_payload_inputs_1;
    if (accept && funct7 == CMD_WR_KER) ker_mem[cmd_payload_inputs_0[KW_AW-1:0]] <= cmd_payload_inputs_1;
  end

  always_ff @(posedge clk) begin
    if (!reset && state == ST_CLEAR)      out_mem[o_q] <= '0;
    else if (!reset && state == ST_RUN && wb_q) out_mem[o_q] <= wb_val;
  end

endmodule

// File: tb/tb_conv1d_stream_engine.sv
// Randomised command-level bench for conv1d_stream_engine against a direct convolution model.
module tb_conv1d_stream_engine;

  localparam int MAX_LEN = 1024;
  localparam int MAX_CH  = 128;
  localparam int KL      = 8;
  localparam int GRP     = MAX_CH / 4;
  localparam int ROWS    = 64;

  localparam logic [6:0] C_CLEAR = 7'd0, C_WR_IN = 7'd1, C_WR_KER = 7'd2, C_RD_OUT = 7'd3;
  localparam logic [6:0] C_START = 7'd4, C_SET_Q = 7'd5, C_SET_CFG = 7'd6, C_STATUS = 7'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0, cmd_payload_inputs_1, rsp_payload_outputs_0;

  always #5 clk = ~clk;

  conv1d_stream_engine #(
    .MAX_LEN(MAX_LEN), .MAX_CH(MAX_CH), .KERNEL_LEN(KL), .ACC_W(32)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int in_m  [ROWS][MAX_CH];
  int ker_m [KL][MAX_CH];
  int len_m, ch_m, bias_m, off_m;
  bit sat8_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_cmd(input logic [6:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output int lat);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_payload_function_id = {f, 3'b000};
    cmd_payload_inputs_0 = a;
    cmd_payload_inputs_1 = b;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check_eq("cmd_accept", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 5000);
    check_eq("rsp_arrives", {31'b0, rsp_valid}, 32'd1);
    r = rsp_payload_outputs_0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic cmd(input logic [6:0] f, input logic [31:0] a, input logic [31:0] b,
                     output logic [31:0] r);
    int lat;
    do_cmd(f, a, b, r, lat);
  endtask

  function automatic logic [31:0] pack_in(input int r, input int g);
    logic [31:0] w = '0;
    for (int l = 0; l < 4; l++) w[31-8*l -: 8] = 8'(in_m[r][4*g+l]);
    return w;
  endfunction

  function automatic logic [31:0] pack_ker(input int k, input int g);
    logic [31:0] w = '0;
    for (int l = 0; l < 4; l++) w[31-8*l -: 8] = 8'(ker_m[k][4*g+l]);
    return w;
  endfunction

  function automatic int ref_out(input int o);
    int acc = 0;
    for (int k = 0; k < KL; k++) begin
      int r = o - KL/2 + k;
      if (r >= 0 && r < len_m)
        for (int c = 0; c < ch_m; c++) acc += (in_m[r][c] + off_m) * ker_m[k][c];
    end
    acc += bias_m;
    if (sat8_m) acc = (acc > 127) ? 127 : (acc < -128) ? -128 : acc;
    return acc;
  endfunction

  task automatic load_all();
    logic [31:0] r;
    for (int row = 0; row < len_m; row++)
      for (int g = 0; g < ch_m/4; g++) begin
        cmd(C_WR_IN, 32'(row*GRP + g), pack_in(row, g), r);
        check_eq("wr_in_rsp", r, 32'd0);
      end
    for (int k = 0; k < KL; k++)
      for (int g = 0; g < ch_m/4; g++) begin
        cmd(C_WR_KER, 32'(k*GRP + g), pack_ker(k, g), r);
        check_eq("wr_ker_rsp", r, 32'd0);
      end
  endtask

  task automatic set_cfg(input int l, input int c);
    logic [31:0] r;
    bit ok = (l >= 1) && (l <= MAX_LEN) && (c % 4 == 0) && (c >= 4) && (c <= MAX_CH);
    cmd(C_SET_CFG, 32'(l), 32'(c), r);
    check_eq("set_cfg_rsp", r, ok ? 32'd0 : 32'd1);
    if (ok) begin
      len_m = l;
      ch_m  = c;
    end
  endtask

  task automatic set_q(input int bias, input int off, input bit s8);
    logic [31:0] r;
    logic [8:0]  o9 = 9'(off);
    cmd(C_SET_Q, 32'(bias), {15'b0, s8, 7'b0, o9}, r);
    check_eq("set_q_rsp", r, 32'd0);
    bias_m = bias;
    off_m  = off;
    sat8_m = s8;
  endtask

  task automatic run_and_check(input string tag);
    logic [31:0] r;
    cmd(C_START, 32'd0, 32'd0, r);
    check_eq({tag, "_cycles"}, r, 32'(len_m * (KL*ch_m/4 + 1)));
    for (int o = 0; o < len_m; o++) begin
      cmd(C_RD_OUT, 32'(o), 32'd0, r);
      check_eq({tag, "_out"}, r, 32'(ref_out(o)));
    end
  endtask

  task automatic fill(input int in_v, input int ker_v);
    for (int row = 0; row < ROWS; row++)
      for (int c = 0; c < MAX_CH; c++) in_m[row][c] = in_v;
    for (int k = 0; k < KL; k++)
      for (int c = 0; c < MAX_CH; c++) ker_m[k][c] = ker_v;
  endtask

  initial begin
    logic [31:0] r;
    int lat;
    reset = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    cmd_payload_function_id = '0;
    cmd_payload_inputs_0 = '0;
    cmd_payload_inputs_1 = '0;
    len_m = MAX_LEN; ch_m = MAX_CH; bias_m = 0; off_m = 0; sat8_m = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("reset_rsp_data", rsp_payload_outputs_0, 32'd0);
    check_eq("reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    cmd(C_STATUS, 0, 0, r);
    check_eq("status_reset", r, 32'd1);
    cmd(7'd9, 0, 0, r);
    check_eq("unknown_code", r, 32'hFFFF_FFFF);

    // Basic all-ones convolution.
    set_cfg(8, 4);
    fill(1, 1);
    load_all();
    set_q(0, 0, 1'b0);
    run_and_check("basic");
    cmd(C_RD_OUT, 0, 0, r); check_eq("basic_out0", r, 32'd16);
    cmd(C_RD_OUT, 4, 0, r); check_eq("basic_out4", r, 32'd32);
    cmd(C_RD_OUT, 7, 0, r); check_eq("basic_out7", r, 32'd20);

    // Offset cancels -128 inputs; sat8 clamps both ways.
    fill(-128, 1);
    load_all();
    set_q(-5, 128, 1'b0);
    run_and_check("offset");
    cmd(C_RD_OUT, 3, 0, r); check_eq("offset_out3", r, 32'hFFFF_FFFB);
    fill(1, 1);
    load_all();
    set_q(100, 0, 1'b1);
    run_and_check("sat_hi");
    cmd(C_RD_OUT, 4, 0, r); check_eq("sat_hi_out4", r, 32'd127);
    set_q(-300, 0, 1'b1);
    run_and_check("sat_lo");
    cmd(C_RD_OUT, 4, 0, r); check_eq("sat_lo_out4", r, 32'hFFFF_FF80);
    cmd(C_STATUS, 0, 0, r);
    check_eq("status_sat8", r, {30'b0, sat8_m, 1'b1});

    // Illegal configurations leave len/ch alone.
    set_cfg(8, 6);
    set_cfg(0, 4);
    set_cfg(MAX_LEN + 1, 4);
    set_cfg(8, MAX_CH + 4);
    set_cfg(8, 0);
    set_q(0, 0, 1'b0);
    run_and_check("cfg_keep");

    // Response held under backpressure; a command offered meanwhile is ignored.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_payload_function_id = {C_WR_IN, 3'b000};
    cmd_payload_inputs_0 = 32'd0;
    cmd_payload_inputs_1 = pack_in(0, 0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check_eq("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check_eq("bp_rsp_data", rsp_payload_outputs_0, 32'd0);
      check_eq("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      if (i == 1) begin
        cmd_valid = 1'b1;
        cmd_payload_function_id = {C_STATUS, 3'b000};
      end else begin
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp_no_extra_rsp", {31'b0, rsp_valid}, 32'd0);
    end

    // Randomised shapes and data, including the single-row boundary.
    for (int t = 0; t < 4; t++) begin
      int l = (t == 0) ? 1 : int'($urandom_range(2, 40));
      int c = 4 * int'($urandom_range(1, 4));
      for (int row = 0; row < ROWS; row++)
        for (int ch = 0; ch < MAX_CH; ch++) in_m[row][ch] = int'($urandom_range(0, 255)) - 128;
      for (int k = 0; k < KL; k++)
        for (int ch = 0; ch < MAX_CH; ch++) ker_m[k][ch] = int'($urandom_range(0, 255)) - 128;
      set_cfg(l, c);
      load_all();
      set_q(int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 511)) - 256,
            1'($urandom_range(0, 1)));
      run_and_check("rand");
    end

    // Synchronous reset in the middle of a run.
    set_cfg(8, 4);
    @(negedge clk);
    check_eq("rst_run_ready", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_payload_function_id = {C_START, 3'b000};
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    len_m = MAX_LEN; ch_m = MAX_CH; bias_m = 0; off_m = 0; sat8_m = 1'b0;
    @(negedge clk);
    check_eq("rst_run_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("rst_run_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    cmd(C_STATUS, 0, 0, r);
    check_eq("rst_run_status", r, 32'd1);

    // CLEAR sweep latency and contents.
    do_cmd(C_CLEAR, 0, 0, r, lat);
    check_eq("clear_rsp", r, 32'd0);
    check_eq("clear_latency", 32'(lat), 32'(MAX_LEN + 1));
    cmd(C_RD_OUT, 0, 0, r);    check_eq("clear_out0", r, 32'd0);
    cmd(C_RD_OUT, 511, 0, r);  check_eq("clear_out511", r, 32'd0);
    cmd(C_RD_OUT, 1023, 0, r); check_eq("clear_out1023", r, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
